// File: rtl/gpi_irq_pkg.sv
// Shared constants for the GPI event/interrupt controller: CSR register offsets
// and the width of the per-input debounce counter.
package gpi_irq_pkg;

    localparam logic [2:0] REG_STATE   = 3'd0;
    localparam logic [2:0] REG_RISE_EN = 3'd1;
    localparam logic [2:0] REG_FALL_EN = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_IRQ_EN  = 3'd4;

    localparam int REG_COUNT = 5;

    // Debounce counter width; enough for DEB_TICKS up to 15.
    localparam int DEB_CNT_W = 4;

endpackage

// File: rtl/gpi_irq_ctrl_if.sv
// 5-bit CSR bus shared by the CSR slaves: address, write data, write strobe
// and combinational read data.
interface gpi_irq_ctrl_if;

    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;

    modport master (output csr_a, output csr_di, output csr_we, input csr_do);
    modport slave  (input csr_a, input csr_di, input csr_we, output csr_do);

endinterface

// File: rtl/gpi_debounce.sv
// One input channel: two-flop synchronizer followed by a tick-driven debouncer.
// With GPI_IRQ_DEBOUNCE_EN undefined the synchronizer output is used directly.
module gpi_debounce
    import gpi_irq_pkg::*;
#(
    parameter int DEB_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic stable
);

    logic sync1;
    logic sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef GPI_IRQ_DEBOUNCE_EN
    localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEB_TICKS - 1);

    logic [DEB_CNT_W-1:0] cnt;
    logic                 stable_q;

    // Any return to the accepted level restarts the count, so only a level held
    // across DEB_TICKS consecutive ticks is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            stable_q <= 1'b0;
        end else if (sync2 == stable_q) begin
            cnt <= '0;
        end else if (tick) begin
            if (cnt == CNT_LAST) begin
                stable_q <= sync2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + DEB_CNT_W'(1);
            end
        end
    end

    assign stable = stable_q;
`else
    localparam int unused_deb_ticks = DEB_TICKS;
    logic unused_tick;

    assign unused_tick = tick;
    assign stable      = sync2;
`endif

endmodule

// File: rtl/gpi_irq_ctrl.sv
// GPI event and interrupt controller: per-input sync/debounce, edge detect,
// W1C status and a registered level interrupt. Debounce built only with GPI_IRQ_DEBOUNCE_EN.
module gpi_irq_ctrl
    import gpi_irq_pkg::*;
#(
    parameter logic [4:0] BASE_ADDR = 5'd0,
    parameter int         NUM_GPIOS = 8,
    parameter int         PRESCALE  = 1000,
    parameter int         DEB_TICKS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    gpi_irq_ctrl_if.slave        csr,
    input  logic [NUM_GPIOS-1:0] in,
    output logic                 irq
);

    logic                 tick;
    logic [NUM_GPIOS-1:0] stable;
    logic [NUM_GPIOS-1:0] stable_prev;
    logic [NUM_GPIOS-1:0] rise_en;
    logic [NUM_GPIOS-1:0] fall_en;
    logic [NUM_GPIOS-1:0] status;
    logic [NUM_GPIOS-1:0] irq_en;
    logic [NUM_GPIOS-1:0] evt;
    logic [NUM_GPIOS-1:0] clr;

`ifdef GPI_IRQ_DEBOUNCE_EN
    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_cnt <= '0;
        end else if (ps_cnt == PS_LAST) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    assign tick = (ps_cnt == PS_LAST);
`else
    localparam int unused_prescale = PRESCALE;

    assign tick = 1'b0;
`endif

    for (genvar g = 0; g < NUM_GPIOS; g++) begin : g_ch
        gpi_debounce #(
            .DEB_TICKS(DEB_TICKS)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .raw   (in[g]),
            .stable(stable[g])
        );
    end

    // Offset wraps modulo 32, so a single compare covers both range bounds.
    logic [4:0] off;
    logic       in_range;
    logic       wr_rise;
    logic       wr_fall;
    logic       wr_status;
    logic       wr_irq;

    assign off       = csr.csr_a - BASE_ADDR;
    assign in_range  = (off < 5'(REG_COUNT));
    assign wr_rise   = csr.csr_we && (off == 5'(REG_RISE_EN));
    assign wr_fall   = csr.csr_we && (off == 5'(REG_FALL_EN));
    assign wr_status = csr.csr_we && (off == 5'(REG_STATUS));
    assign wr_irq    = csr.csr_we && (off == 5'(REG_IRQ_EN));

    assign evt = (stable & ~stable_prev & rise_en) | (~stable & stable_prev & fall_en);
    assign clr = wr_status ? csr.csr_di[NUM_GPIOS-1:0] : '0;

    // A new event is OR-ed in after the clear so it survives a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_prev <= '0;
            rise_en     <= '0;
            fall_en     <= '0;
            status      <= '0;
            irq_en      <= '0;
            irq         <= 1'b0;
        end else begin
            stable_prev <= stable;
            if (wr_rise) rise_en <= csr.csr_di[NUM_GPIOS-1:0];
            if (wr_fall) fall_en <= csr.csr_di[NUM_GPIOS-1:0];
            if (wr_irq)  irq_en  <= csr.csr_di[NUM_GPIOS-1:0];
            status <= (status & ~clr) | evt;
            irq    <= |(status & irq_en);
        end
    end

    logic [7:0] rd;

    always_comb begin
        rd = '0;
        if (in_range) begin
            case (off[2:0])
                REG_STATE:   rd[NUM_GPIOS-1:0] = stable;
                REG_RISE_EN: rd[NUM_GPIOS-1:0] = rise_en;
                REG_FALL_EN: rd[NUM_GPIOS-1:0] = fall_en;
                REG_STATUS:  rd[NUM_GPIOS-1:0] = status;
                REG_IRQ_EN:  rd[NUM_GPIOS-1:0] = irq_en;
                default:     rd = '0;
            endcase
        end
    end

    assign csr.csr_do = rd;

endmodule
